// File: rtl/mem_bus_master_if.sv
// Request/response handshake and narrow memory-bus signals for mem_bus_master.
// The master modport is the controller's view; slave is the requester/memory side.
interface mem_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic [11:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [11:0] rsp_data;
    logic        wr_done;
    logic        read_write;
    logic        write_commit;
    logic [9:0]  addr_data;
    logic [11:0] mem_result;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, mem_result,
        output req_ready, rsp_valid, rsp_data, wr_done, read_write, write_commit, addr_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready, mem_result,
        input  req_ready, rsp_valid, rsp_data, wr_done, read_write, write_commit, addr_data
    );
endinterface

// File: rtl/mem_bus_master.sv
// Converts word read/write requests into cycles on a 10-bit multiplexed memory bus,
// writing 12-bit words as two 6-bit halves and skipping redundant address loads.
module mem_bus_master (
    input logic               clk,
    input logic               rst,
    mem_bus_master_if.master  bus
);

    typedef enum logic [2:0] {IDLE, WADDR, WLO, WHI, RADDR, RCAP, RSP} state_t;

    state_t      state, nxt;

    logic        req_ready_q, rsp_valid_q, wr_done_q, read_write_q, write_commit_q;
    logic [11:0] rsp_data_q;
    logic [9:0]  addr_data_q;
    logic        shadow_valid;
    logic [9:0]  shadow_addr;
    logic [9:0]  lat_addr;
    logic [11:0] lat_wdata;
    logic [1:0]  lat_be;

    logic        req_ready_d, rsp_valid_d, wr_done_d, read_write_d, write_commit_d;
    logic [11:0] rsp_data_d;
    logic [9:0]  addr_data_d;
    logic        shadow_load;
    logic        accept;
    logic [9:0]  src_addr;
    logic [11:0] src_wdata;

    function automatic logic [9:0] half_field(input logic upper, input logic [11:0] wdata);
        return upper ? {3'b000, 1'b1, wdata[11:6]} : {3'b000, 1'b0, wdata[5:0]};
    endfunction

    assign accept = bus.req_valid && req_ready_q;

    // Bus outputs are registered from the next state, so the first cycle after
    // acceptance must source the request fields directly rather than the latches.
    assign src_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
    assign src_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;

    always_comb begin
        nxt         = state;
        shadow_load = 1'b0;
        wr_done_d   = 1'b0;
        rsp_data_d  = rsp_data_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_write) begin
                        if (bus.req_be == 2'b00) begin
                            wr_done_d = 1'b1;
                        end else if (shadow_valid && (bus.req_addr == shadow_addr)) begin
                            nxt = bus.req_be[0] ? WLO : WHI;
                        end else begin
                            nxt         = WADDR;
                            shadow_load = 1'b1;
                        end
                    end else begin
                        nxt = RADDR;
                    end
                end
            end
            WADDR: nxt = lat_be[0] ? WLO : WHI;
            WLO: begin
                if (lat_be[1]) begin
                    nxt = WHI;
                end else begin
                    nxt       = IDLE;
                    wr_done_d = 1'b1;
                end
            end
            WHI: begin
                nxt       = IDLE;
                wr_done_d = 1'b1;
            end
            RADDR: nxt = RCAP;
            RCAP: begin
                nxt        = RSP;
                rsp_data_d = bus.mem_result;
            end
            RSP: if (bus.rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase

        read_write_d   = 1'b1;
        write_commit_d = 1'b0;
        addr_data_d    = '0;
        case (nxt)
            WADDR: begin
                read_write_d = 1'b0;
                addr_data_d  = src_addr;
            end
            WLO: begin
                read_write_d   = 1'b0;
                write_commit_d = 1'b1;
                addr_data_d    = half_field(1'b0, src_wdata);
            end
            WHI: begin
                read_write_d   = 1'b0;
                write_commit_d = 1'b1;
                addr_data_d    = half_field(1'b1, src_wdata);
            end
            RADDR: addr_data_d = src_addr;
            default: ;
        endcase

        req_ready_d = (nxt == IDLE);
        rsp_valid_d = (nxt == RSP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            req_ready_q    <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_data_q     <= '0;
            wr_done_q      <= 1'b0;
            read_write_q   <= 1'b1;
            write_commit_q <= 1'b0;
            addr_data_q    <= '0;
            shadow_valid   <= 1'b0;
        end else begin
            state          <= nxt;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            wr_done_q      <= wr_done_d;
            read_write_q   <= read_write_d;
            write_commit_q <= write_commit_d;
            addr_data_q    <= addr_data_d;
            if (shadow_load) shadow_valid <= 1'b1;
        end
    end

    // Request payload and shadow address are qualified by state/shadow_valid, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            lat_be    <= bus.req_be;
        end
        if (shadow_load) shadow_addr <= bus.req_addr;
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.wr_done      = wr_done_q;
    assign bus.read_write   = read_write_q;
    assign bus.write_commit = write_commit_q;
    assign bus.addr_data    = addr_data_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed plus randomized bench for mem_bus_master with a bus-level memory and a
// transaction-level reference model of memory contents and the write-address shadow.
module tb_mem_bus_master;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    logic [11:0] ref_mem [1024];
    logic        sh_v;
    logic [9:0]  sh_a;

    mem_bus_master_if bus ();

    mem_bus_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] init_val(input int i);
        logic [11:0] v;
        v = 12'(i * 37) ^ 12'h5A5;
        if (i == 1023) v = 12'hFFF;
        return v;
    endfunction

    // Memory on the far side of the bus: latches write address, commits halves,
    // returns read data one cycle after the address is driven.
    logic [11:0] tb_mem [1024];
    logic [9:0]  tb_waddr;
    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = init_val(i);
        tb_waddr = '0;
        bus.mem_result = '0;
        forever begin
            @(posedge clk);
            bus.mem_result <= tb_mem[bus.addr_data];
            if (!bus.read_write && !bus.write_commit) begin
                tb_waddr = bus.addr_data;
            end else if (!bus.read_write && bus.write_commit) begin
                if (bus.addr_data[6]) tb_mem[tb_waddr][11:6] = bus.addr_data[5:0];
                else                  tb_mem[tb_waddr][5:0]  = bus.addr_data[5:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bus_word();
        return {20'd0, bus.read_write, bus.write_commit, bus.addr_data};
    endfunction

    task automatic do_write(input logic [9:0] a, input logic [11:0] d, input logic [1:0] be);
        logic [11:0] exp_q [$];
        chk("w_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        if (be != 2'b00) begin
            if (!(sh_v && sh_a == a)) begin
                exp_q.push_back({2'b00, a});
                sh_v = 1'b1;
                sh_a = a;
            end
            if (be[0]) begin
                exp_q.push_back({2'b01, 4'b0000, d[5:0]});
                ref_mem[a][5:0] = d[5:0];
            end
            if (be[1]) begin
                exp_q.push_back({2'b01, 4'b0001, d[11:6]});
                ref_mem[a][11:6] = d[11:6];
            end
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 10'($urandom);
        bus.req_wdata = 12'($urandom);
        bus.req_be    = 2'($urandom);
        foreach (exp_q[i]) begin
            chk("w_bus", bus_word(), 32'(exp_q[i]));
            chk("w_busy_ready", bus.req_ready, 0);
            chk("w_early_done", bus.wr_done, 0);
            @(negedge clk);
        end
        chk("w_done", bus.wr_done, 1);
        chk("w_end_ready", bus.req_ready, 1);
        chk("w_end_bus", bus_word(), 32'h800);
    endtask

    task automatic do_read(input logic [9:0] a, input int hold);
        chk("r_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        bus.req_be    = 2'($urandom);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 10'($urandom);
        chk("r_addr_bus", bus_word(), {22'd0, 2'b10, a});
        chk("r_early_valid1", bus.rsp_valid, 0);
        @(negedge clk);
        chk("r_cap_bus", bus_word(), 32'h800);
        chk("r_early_valid2", bus.rsp_valid, 0);
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            chk("r_hold_valid", bus.rsp_valid, 1);
            chk("r_hold_data", bus.rsp_data, 32'(ref_mem[a]));
            chk("r_hold_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        chk("r_valid", bus.rsp_valid, 1);
        chk("r_data", bus.rsp_data, 32'(ref_mem[a]));
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("r_end_valid", bus.rsp_valid, 0);
        chk("r_end_ready", bus.req_ready, 1);
        chk("r_no_wrdone", bus.wr_done, 0);
    endtask

    initial begin
        logic [9:0]  ra;
        logic [11:0] rd;
        passed = 0;
        total  = 0;
        sh_v   = 1'b0;
        sh_a   = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_be    = '0;
        bus.rsp_ready = 1'b0;

        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_wr_done", bus.wr_done, 0);
        chk("rst_bus", bus_word(), 32'h800);
        @(negedge clk);
        chk("rst_hold_ready", bus.req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bus.req_ready, 1);

        do_write(10'd5, 12'hABC, 2'b11);
        do_write(10'd5, 12'h123, 2'b01);
        do_read(10'd5, 0);
        do_read(10'd1023, 5);
        do_write(10'd9, 12'h456, 2'b00);
        do_write(10'd5, 12'h777, 2'b10);
        do_write(10'd0, 12'h0F0, 2'b11);
        do_read(10'd0, 1);
        do_read(10'd1023, 0);

        // Reset asserted during the low-half commit of a full write.
        ra = (sh_v && sh_a == 10'd77) ? 10'd78 : 10'd77;
        rd = 12'h5C3;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = ra;
        bus.req_wdata = rd;
        bus.req_be    = 2'b11;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("ra_waddr", bus_word(), {22'd0, 2'b00, ra});
        @(negedge clk);
        chk("ra_wlo", bus_word(), {22'd0, 2'b01, 4'b0000, rd[5:0]});
        #1 rst = 1'b0;
        #1;
        chk("ra_req_ready", bus.req_ready, 0);
        chk("ra_rsp_valid", bus.rsp_valid, 0);
        chk("ra_rsp_data", bus.rsp_data, 0);
        chk("ra_wr_done", bus.wr_done, 0);
        chk("ra_bus", bus_word(), 32'h800);
        sh_v = 1'b0;
        @(negedge clk);
        chk("ra_hold_done", bus.wr_done, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ra_post_ready", bus.req_ready, 1);
        chk("ra_post_done", bus.wr_done, 0);
        do_write(ra, rd, 2'b11);
        do_read(ra, 2);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(3))
                0: ra = 10'd0;
                1: ra = 10'd1023;
                2: ra = 10'($urandom_range(4, 7));
                default: ra = 10'($urandom);
            endcase
            if ($urandom_range(1) == 0) do_write(ra, 12'($urandom), 2'($urandom));
            else                        do_read(ra, $urandom_range(3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
